// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side valid/ready bundle plus the FIFO write port for fifo_wr_arbiter.
// With FIFO_ARB_TAG_EN defined, fifo_data also carries the source index.
interface fifo_wr_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int IW = $clog2(NUM_PORTS);
`ifdef FIFO_ARB_TAG_EN
  localparam int FIFO_WIDTH = DATA_WIDTH + 1 + IW;
`else
  localparam int FIFO_WIDTH = DATA_WIDTH + 1;
`endif

  logic [NUM_PORTS-1:0]            s_tvalid;
  logic [NUM_PORTS-1:0]            s_tready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_PORTS-1:0]            s_tlast;
  logic [FIFO_WIDTH-1:0]           fifo_data;
  logic                            fifo_wr;
  logic                            fifo_full;
  logic                            grant_valid;
  logic [IW-1:0]                   grant_idx;

  modport slave (
    input  s_tvalid, s_tdata, s_tlast, fifo_full,
    output s_tready, fifo_data, fifo_wr,
    output grant_valid, grant_idx
  );

  modport master (
    output s_tvalid, s_tdata, s_tlast, fifo_full,
    input  s_tready, fifo_data, fifo_wr,
    input  grant_valid, grant_idx
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one sync_fifo write port.
// Optional FIFO_ARB_TAG_EN prepends the granted index to fifo_data.
module fifo_wr_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  localparam logic [CW-1:0] CNT_CAP  = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_PORTS - 1);

  logic [0:0]            state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  pick_any;
  logic [IW-1:0]         pick_idx;
  logic                  locked;
  logic                  beat;
  logic                  done;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;

  // Descending scan so the nearest requester after last_q wins.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (bus.s_tvalid[(int'(last_q) + k) % NUM_PORTS]) begin
        pick_any = 1'b1;
        pick_idx = IW'((int'(last_q) + k) % NUM_PORTS);
      end
    end
  end

  assign g_valid = bus.s_tvalid[grant_q];
  assign g_last  = bus.s_tlast[grant_q];
  assign g_data  = bus.s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];

  assign locked = (state_q == S_LOCKED) & ~rst;
  assign beat   = locked & g_valid & ~bus.fifo_full;
  assign done   = beat & (g_last | (cnt_q == CNT_CAP));

  always_comb begin
    bus.s_tready = '0;
    if (locked & ~bus.fifo_full) begin
      bus.s_tready[grant_q] = 1'b1;
    end
  end

  assign bus.fifo_wr     = beat;
  assign bus.grant_valid = (state_q == S_LOCKED);
  assign bus.grant_idx   = grant_q;

`ifdef FIFO_ARB_TAG_EN
  assign bus.fifo_data = {grant_q, g_last, g_data};
`else
  assign bus.fifo_data = {g_last, g_data};
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d = S_LOCKED;
          grant_d = pick_idx;
          cnt_d   = '0;
        end
      end
      S_LOCKED: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (done) begin
          state_d = S_IDLE;
          last_d  = grant_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
